fft_ram_reader: RTL and testbench
=================================

Name: fft_ram_reader

Overview:
- Read-side streaming engine for the shared-butterfly FFT sample/result memory.
- On `start`, it fetches a block of words from the dual-port RAM read port, beginning at `base_addr`, using that RAM's 1-cycle registered read latency.
- It presents the words on a valid/ready output stream with `m_last`, and absorbs back-pressure in a 2-entry output buffer.
- Sustained throughput is one word per cycle while `m_ready` stays high.

Parameters:
- DATA_WIDTH, 32, word width; must match the RAM.
- ADDR_WIDTH, 13, RAM address width; the RAM depth is 2^ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a transfer; ignored while busy=1.
- base_addr  input  ADDR_WIDTH  first RAM address; sampled when start is accepted.
- len  input  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH; sampled when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at the end of a transfer.
- rd_addr  output  ADDR_WIDTH  connects to the RAM read address; registered.
- rd_data  input  DATA_WIDTH  connects to the RAM read data; valid the cycle after the fetch.
- m_data  output  DATA_WIDTH  output stream data.
- m_valid  output  1  output stream valid.
- m_ready  input  1  output stream ready.
- m_last  output  1  high with the final word of a transfer.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, done, m_valid, m_last = 0.
  - rd_addr = 0, m_data = 0.
  - Buffer, in-flight flag and counters cleared.
  - A reset mid-transfer abandons the transfer; no done pulse is produced.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE -> RUN: start=1 and len!=0. Latches base_addr and len; sets remaining-fetch and remaining-send counters to len.
  - IDLE -> IDLE: start=1 and len=0. done pulses the next cycle; busy stays 0.
  - RUN -> FLUSH: the final fetch has been issued.
  - FLUSH -> IDLE: the word flagged last completes a handshake (m_valid & m_ready). done=1 in the following cycle.
- Fetch rules:
  - A fetch in cycle c means rd_addr holds the target address during c; the RAM samples it at the end of c.
  - rd_data is captured into the buffer at the end of c+1 (in-flight flag set for exactly one cycle).
  - A fetch is permitted in RUN when (buf_count + inflight - pop) < 2, where pop = m_valid & m_ready in the same cycle.
  - rd_addr advances by 1 after each fetch, modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0).
  - No fetches occur in IDLE or FLUSH. rd_addr holds its last value there.
- Latency: start accepted at edge E0 -> first fetch in cycle 1 -> m_valid=1 in cycle 3. With m_ready held high, words follow in consecutive cycles.
- Output buffer:
  - 2-entry FIFO; m_data is its head entry.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - Simultaneous push and pop keep the count unchanged.
  - The buffer never overflows; this follows from the fetch rule.
- m_last is asserted on, and only on, the entry corresponding to fetch number len.
- start arriving while busy=1 has no effect.
- The len and base_addr inputs may change freely after they are sampled.

Optional Feature:
- Macro: FFT_READER_BIT_REVERSE_EN.
- Defined:
  - Transfer length is fixed at 2^ADDR_WIDTH; the len port is ignored, except that len=0 still completes as an immediate done.
  - The emitted address for fetch index i is base_addr XOR bitrev_ADDR_WIDTH(i). With base_addr=0, this is natural-order readout of a bit-reversed FFT result.
- Undefined: addresses are sequential (base_addr + i, modulo 2^ADDR_WIDTH).

Test Plan:
- RAM preloaded with mem[k]=k; start with base_addr=0, len=8, m_ready=1 -> m_valid first high 3 cycles after start; m_data = 0..7 on 8 consecutive cycles; m_last only with 7; done one cycle after.
- base_addr=8190, len=4, ADDR_WIDTH=13 -> rd_addr sequence 8190, 8191, 0, 1; data in that order.
- len=6, m_ready toggling 1,0,0,1,0,1,... -> no word lost or duplicated; m_data stable during stalls; at most 2 words buffered; exactly 6 handshakes.
- len=0 -> no fetch, m_valid stays 0, done pulses the next cycle, busy stays 0; a second start during a len=16 transfer is ignored.
- rst_n pulled low mid-transfer (after 3 of 10 words) -> all outputs 0 immediately; a new start with len=2 afterwards runs cleanly.
- With FFT_READER_BIT_REVERSE_EN and ADDR_WIDTH=3, base_addr=0 -> rd_addr sequence 0,4,2,6,1,5,3,7; m_last on the 8th word.

Source files
------------

// File: rtl/fft_ram_reader.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | fft_ram_reader: streams a block of FFT RAM words onto a valid/ready port.    |
// | Optional FFT_READER_BIT_REVERSE_EN: full-depth bit-reversed readout. Rev 1.0 |
// +------------------------------------------------------------------------------+
module fft_ram_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   c_len_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH:0]    fetch_left_q, fetch_left_d;
   logic                   inflight_q, inflight_d;
   logic                   inflight_last_q, inflight_last_d;
   logic                   done_q, done_d;
   logic [1:0]             count_q, count_d;
   logic [DATA_WIDTH-1:0]  buf0_data_q, buf0_data_d;
   logic [DATA_WIDTH-1:0]  buf1_data_q, buf1_data_d;
   logic                   buf0_last_q, buf0_last_d;
   logic                   buf1_last_q, buf1_last_d;

   logic                   pop;
   logic                   fetch;
   logic                   push_to_buf1;
   logic [2:0]             occupancy;
   logic [ADDR_WIDTH:0]    xfer_len;
   logic [ADDR_WIDTH-1:0]  next_addr;

`ifdef FFT_READER_BIT_REVERSE_EN
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [ADDR_WIDTH-1:0]  fetch_idx_q, fetch_idx_d;
   logic [ADDR_WIDTH-1:0]  idx_next;

   function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] v);
      logic [ADDR_WIDTH-1:0] r;
      for (int i = 0; i < ADDR_WIDTH; i++) begin
         r[i] = v[ADDR_WIDTH-1-i];
      end
      return r;
   endfunction

   assign xfer_len  = {1'b1, {ADDR_WIDTH{1'b0}}};
   assign idx_next  = fetch_idx_q + c_addr_one;
   assign next_addr = base_q ^ bitrev(idx_next);
`else
   assign xfer_len  = len;
   assign next_addr = rd_addr_q + c_addr_one;
`endif

   assign m_valid   = (count_q != 2'd0);
   assign pop       = m_valid & m_ready;
   // Words already owned (buffered or in flight) after this cycle's pop must leave room.
   assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fetch     = (state_q == S_RUN) && (fetch_left_q != '0) && (occupancy < 3'd2);

   always_comb begin
      state_d         = state_q;
      rd_addr_d       = rd_addr_q;
      fetch_left_d    = fetch_left_q;
      inflight_d      = fetch;
      inflight_last_d = fetch && (fetch_left_q == c_len_one);
      done_d          = 1'b0;
`ifdef FFT_READER_BIT_REVERSE_EN
      base_d          = base_q;
      fetch_idx_d     = fetch_idx_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d      = S_RUN;
                  rd_addr_d    = base_addr;
                  fetch_left_d = xfer_len;
`ifdef FFT_READER_BIT_REVERSE_EN
                  base_d       = base_addr;
                  fetch_idx_d  = '0;
`endif
               end
            end
         end
         S_RUN: begin
            if (fetch) begin
               fetch_left_d = fetch_left_q - c_len_one;
               rd_addr_d    = next_addr;
`ifdef FFT_READER_BIT_REVERSE_EN
               fetch_idx_d  = idx_next;
`endif
               if (fetch_left_q == c_len_one) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (pop && buf0_last_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Head is entry 0; a pop shifts entry 1 down before any push lands.
   assign push_to_buf1 = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

   always_comb begin
      buf0_data_d = buf0_data_q;
      buf0_last_d = buf0_last_q;
      buf1_data_d = buf1_data_q;
      buf1_last_d = buf1_last_q;
      count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};
      if (pop) begin
         buf0_data_d = buf1_data_q;
         buf0_last_d = buf1_last_q;
         buf1_last_d = 1'b0;
      end
      if (inflight_q) begin
         if (push_to_buf1) begin
            buf1_data_d = rd_data;
            buf1_last_d = inflight_last_q;
         end else begin
            buf0_data_d = rd_data;
            buf0_last_d = inflight_last_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         rd_addr_q       <= '0;
         fetch_left_q    <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
         count_q         <= 2'd0;
         buf0_data_q     <= '0;
         buf1_data_q     <= '0;
         buf0_last_q     <= 1'b0;
         buf1_last_q     <= 1'b0;
`ifdef FFT_READER_BIT_REVERSE_EN
         base_q          <= '0;
         fetch_idx_q     <= '0;
`endif
      end else begin
         state_q         <= state_d;
         rd_addr_q       <= rd_addr_d;
         fetch_left_q    <= fetch_left_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
         count_q         <= count_d;
         buf0_data_q     <= buf0_data_d;
         buf1_data_q     <= buf1_data_d;
         buf0_last_q     <= buf0_last_d;
         buf1_last_q     <= buf1_last_d;
`ifdef FFT_READER_BIT_REVERSE_EN
         base_q          <= base_d;
         fetch_idx_q     <= fetch_idx_d;
`endif
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign rd_addr = rd_addr_q;
   assign m_data  = buf0_data_q;
   assign m_last  = m_valid & buf0_last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_ram_reader.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_fft_ram_reader: self-checking bench with a RAM model and word scoreboard. |
// | Follows FFT_READER_BIT_REVERSE_EN when defined. Rev 1.0                      |
// +------------------------------------------------------------------------------+
module tb_fft_ram_reader;

   localparam int AW = 13;
   localparam int DW = 32;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;

   logic [DW-1:0] mem [0:DEPTH-1];

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   len;
      int            mode;
      logic [DW-1:0] exp_last;
   } vec_t;

   vec_t tbl[$];

   fft_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_last    (m_last)
   );

   always #5 clk = ~clk;

   // Dual-port RAM read side: one-cycle registered read.
   always @(posedge clk) rd_data <= mem[rd_addr];

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int bit_reverse(input int v);
      int r = 0;
      for (int b = 0; b < AW; b++) r = r * 2 + ((v >> b) & 1);
      return r;
   endfunction

   function automatic int ref_addr(input int base, input int i);
`ifdef FFT_READER_BIT_REVERSE_EN
      return base ^ bit_reverse(i);
`else
      return (base + i) % DEPTH;
`endif
   endfunction

   function automatic int eff_len(input int l);
`ifdef FFT_READER_BIT_REVERSE_EN
      return (l == 0) ? 0 : DEPTH;
`else
      return l;
`endif
   endfunction

   function automatic logic ready_for(input int mode, input int cyc);
      int pat [6] = '{1, 0, 0, 1, 0, 1};
      case (mode)
         0:       return 1'b1;
         1:       return pat[cyc % 6] != 0;
         2:       return ($urandom % 2) != 0;
         default: return ($urandom % 4) == 0;
      endcase
   endfunction

   task automatic run_transfer(input int base, input int l, input int mode, input int intrude,
                               input bit chk_last, input logic [DW-1:0] exp_last);
      logic [DW-1:0] q[$];
      logic [DW-1:0] prev_data, last_data;
      logic          prev_last;
      bit            prev_stall, expect_done, finished;
      int            n, cyc, got, first_valid, budget;
      n = eff_len(l);
      for (int i = 0; i < n; i++) q.push_back(mem[ref_addr(base, i)]);
      budget = n * 8 + 60;
      @(negedge clk);
      start = 1'b1; base_addr = AW'(base); len = (AW+1)'(l); m_ready = ready_for(mode, 0);
      @(negedge clk);
      start = 1'b0; base_addr = AW'($urandom); len = (AW+1)'($urandom);
      chk("busy_after_start", busy, 1);
      chk("first_rd_addr", rd_addr, base);
      cyc = 1; got = 0; first_valid = -1; prev_stall = 0; expect_done = 0; finished = 0;
      prev_data = '0; prev_last = 0; last_data = '0;
      while (!finished && cyc < budget) begin
         m_ready = ready_for(mode, cyc);
         if (cyc == intrude) begin
            start = 1'b1; base_addr = AW'($urandom); len = (AW+1)'(2);
         end else begin
            start = 1'b0;
         end
         if (m_valid && first_valid < 0) first_valid = cyc;
         if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
         end
         if (expect_done) begin
            chk("done_pulse", done, 1);
            chk("busy_at_done", busy, 0);
            chk("valid_at_done", m_valid, 0);
            finished = 1;
         end else begin
            chk("no_early_done", done, 0);
            if (m_valid && m_ready) begin
               if (q.size() == 0) begin
                  chk("extra_word", 1, 0);
               end else begin
                  chk("word_data", m_data, q.pop_front());
               end
               chk("word_last", m_last, (got == n - 1) ? 1 : 0);
               if (mode == 0) chk("throughput", cyc, 3 + got);
               last_data = m_data;
               got++;
               if (got == n) expect_done = 1;
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!finished) chk("transfer_timeout", cyc, budget + 1);
      chk("word_count", got, n);
      chk("first_valid_latency", first_valid, 3);
      if (chk_last) chk("last_word", last_data, exp_last);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int cnt, cyc;
      logic [AW-1:0] a0;
      for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k);
      rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_m_data", m_data, 0);
      rst_n = 1'b1;

`ifdef FFT_READER_BIT_REVERSE_EN
      tbl.push_back('{base: 13'd0, len: 14'd8, mode: 0, exp_last: 32'd8191});
      tbl.push_back('{base: 13'd5, len: 14'd3, mode: 0, exp_last: 32'd8186});
`else
      tbl.push_back('{base: 13'd0,    len: 14'd8,    mode: 0, exp_last: 32'd7});
      tbl.push_back('{base: 13'd8190, len: 14'd4,    mode: 0, exp_last: 32'd1});
      tbl.push_back('{base: 13'h100,  len: 14'd6,    mode: 1, exp_last: 32'h105});
      tbl.push_back('{base: 13'd8191, len: 14'd1,    mode: 0, exp_last: 32'd8191});
      tbl.push_back('{base: 13'd10,   len: 14'd16,   mode: 3, exp_last: 32'd25});
      tbl.push_back('{base: 13'd8185, len: 14'd12,   mode: 2, exp_last: 32'd4});
      tbl.push_back('{base: 13'd0,    len: 14'd8192, mode: 0, exp_last: 32'd8191});
`endif
      foreach (tbl[v]) run_transfer(int'(tbl[v].base), int'(tbl[v].len), tbl[v].mode, 0, 1, tbl[v].exp_last);

      // Zero-length request: immediate done, no fetch, never busy.
      @(negedge clk);
      a0 = rd_addr;
      start = 1'b1; base_addr = 13'd77; len = '0; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_valid", m_valid, 0);
      chk("len0_rd_addr", rd_addr, a0);
      @(negedge clk);
      chk("len0_done_clear", done, 0);
      chk("len0_valid_after", m_valid, 0);

      // Second start while busy must be ignored.
`ifdef FFT_READER_BIT_REVERSE_EN
      run_transfer(100, 16, 0, 5, 1, 32'd8091);
`else
      run_transfer(100, 16, 0, 5, 1, 32'd115);
`endif

      // Reset in the middle of a transfer.
      @(negedge clk);
      start = 1'b1; base_addr = 13'd50; len = 14'd10; m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0; cyc = 0;
      while (cnt < 3 && cyc < 50) begin
         if (m_valid && m_ready) cnt++;
         @(negedge clk);
         cyc++;
      end
      chk("reset_pre_words", cnt, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_valid", m_valid, 0);
      chk("midrst_last", m_last, 0);
      chk("midrst_rd_addr", rd_addr, 0);
      chk("midrst_m_data", m_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_no_done", done, 0);
`ifdef FFT_READER_BIT_REVERSE_EN
      run_transfer(20, 2, 0, 0, 1, 32'd8171);
`else
      run_transfer(20, 2, 0, 0, 1, 32'd21);
`endif

      // Randomized transfers over random RAM contents.
      for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
`ifdef FFT_READER_BIT_REVERSE_EN
      run_transfer(int'($urandom % DEPTH), 1 + int'($urandom % 40), 0, 0, 0, '0);
`else
      for (int r = 0; r < 10; r++) begin
         int b;
         b = (r % 3 == 0) ? DEPTH - 1 - int'($urandom % 20) : int'($urandom % DEPTH);
         run_transfer(b, 1 + int'($urandom % 40), int'($urandom % 4), 0, 0, '0);
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
